// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - CAM line allocator and round-robin lookup scheduler.
// Destructive lookups (pop) exist only when CAM_CTRL_POP_EN is defined.
module cam_ctrl #(
  parameter  int CAM_DW = 32,
  parameter  int CAM_MW = 3,
  parameter  int CAM_AW = 8,
  parameter  int NREQ   = 2,
  localparam int DEPTH  = 1 << CAM_AW,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [CAM_DW-1:0]      wr_data,
  input  logic [NREQ-1:0]        lk_req,
  input  logic [NREQ*CAM_MW-1:0] lk_mask,
  input  logic [NREQ*CAM_MW-1:0] lk_strb,
  input  logic [NREQ-1:0]        lk_pop,
  output logic [NREQ-1:0]        lk_gnt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_hit,
  output logic [CAM_DW-1:0]      rsp_data,
  output logic [CAM_AW-1:0]      rsp_addr,
  output logic [CAM_DW-1:0]      cam_data_in,
  output logic [CAM_AW-1:0]      cam_addr_in,
  output logic                   cam_input_valid,
  output logic [CAM_MW-1:0]      cam_mask_in,
  output logic [CAM_MW-1:0]      cam_mask_strb,
  output logic                   cam_mask_en,
  output logic                   cam_data_valid,
  input  logic [CAM_DW-1:0]      cam_data_out,
  input  logic [CAM_AW-1:0]      cam_addr_out,
  input  logic                   cam_hit,
  output logic                   full,
  output logic                   empty,
  output logic [CAM_AW:0]        count
);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDW-1:0]    r_idx;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    w_winner;
  logic [IDW-1:0]    w_j;
  logic              w_any_req;
  logic [DEPTH-1:0]  r_shadow;
  logic [CAM_AW:0]   r_count;
  logic [CAM_AW-1:0] w_free_addr;
  logic              w_wr_acc;
  logic              w_pop;

  assign count    = r_count;
  assign full     = (r_count == (CAM_AW+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign wr_ready = !full;

  assign w_wr_acc        = wr_valid && wr_ready && !rst;
  assign cam_input_valid = w_wr_acc;
  assign cam_data_in     = w_wr_acc ? wr_data : '0;
  assign cam_addr_in     = w_wr_acc ? w_free_addr : '0;
  assign rsp_valid       = (r_state == S_RESP);

  // Lowest free line wins: scan downward so the last assignment is the smallest index.
  always_comb begin
    w_free_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_shadow[i]) w_free_addr = CAM_AW'(i);
    end
  end

  always_comb begin
    w_any_req = 1'b0;
    w_winner  = '0;
    w_j       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (lk_req[w_j]) begin
        w_any_req = 1'b1;
        w_winner  = w_j;
      end
    end
  end

`ifdef CAM_CTRL_POP_EN
  assign w_pop = (r_state == S_LOOKUP) && cam_hit && lk_pop[r_idx];
`else
  logic w_unused_pop;
  assign w_unused_pop = ^lk_pop;
  assign w_pop        = 1'b0;
`endif
  assign cam_data_valid = w_pop;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    lk_gnt        = '0;
    cam_mask_en   = 1'b0;
    cam_mask_in   = '0;
    cam_mask_strb = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        lk_gnt[r_idx] = 1'b1;
        cam_mask_en   = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
          if (IDW'(i) == r_idx) begin
            cam_mask_in   = lk_mask[i*CAM_MW +: CAM_MW];
            cam_mask_strb = lk_strb[i*CAM_MW +: CAM_MW];
          end
        end
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_rr_ptr <= '0;
      rsp_id   <= '0;
      rsp_hit  <= 1'b0;
      rsp_data <= '0;
      rsp_addr <= '0;
      r_shadow <= '0;
      r_count  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_idx    <= w_winner;
        r_rr_ptr <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);
      end
      if (r_state == S_LOOKUP) begin
        rsp_id   <= r_idx;
        rsp_hit  <= cam_hit;
        rsp_data <= cam_hit ? cam_data_out : '0;
        rsp_addr <= cam_hit ? cam_addr_out : '0;
      end
      // Pop targets an occupied line and a write a free one, so both may update together.
      if (w_pop)    r_shadow[cam_addr_out] <= 1'b0;
      if (w_wr_acc) r_shadow[w_free_addr]  <= 1'b1;
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + (CAM_AW+1)'(1);
        2'b01:   r_count <= r_count - (CAM_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/cam_ctrl.md
# cam_ctrl

Controller and scheduler in front of the CAM datapath. It allocates free CAM lines for incoming writes and arbitrates lookup/pop requests from NREQ requesters round-robin. It sequences each lookup through a fixed IDLE→LOOKUP→RESP cycle and keeps a shadow occupancy bitmap and fill count consistent with the CAM contents. All CAM control pins are driven only by this block.

## Interface
- CAM_DW, 32, CAM data width
- CAM_MW, 3, mask width (compared against data MSBs)
- CAM_AW, 8, CAM address width; DEPTH = 1<<CAM_AW
- NREQ, 2, number of lookup requesters (≥1)

Ports:
- clk  in  1  clock, single clock domain
- rst  in  1  reset, synchronous, active-high
- wr_valid / wr_ready  in / out  1  write handshake; wr_ready = !full
- wr_data  in  CAM_DW  data to store
- lk_req  in  NREQ  lookup request per requester, held until lk_gnt
- lk_mask, lk_strb  in  NREQ*CAM_MW  per-requester mask / strobe, slice i for requester i
- lk_pop  in  NREQ  per-requester: clear the hit line on lookup
- lk_gnt  out  NREQ  one-hot grant, one-cycle pulse
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_id  out  $clog2(NREQ) (min 1)  granted requester index
- rsp_hit  out  1  lookup hit
- rsp_data  out  CAM_DW  hit data, 0 on miss
- rsp_addr  out  CAM_AW  hit line, 0 on miss
- cam_data_in, cam_addr_in, cam_input_valid  out  CAM write port
- cam_mask_in, cam_mask_strb, cam_mask_en, cam_data_valid  out  CAM match/pop port
- cam_data_out, cam_addr_out, cam_hit  in  CAM results
- full, empty  out  1  occupancy status
- count  out  CAM_AW+1  occupied lines

## Operation
- Write path:
  - Accept when wr_valid && wr_ready.
  - Same cycle, drive cam_input_valid=1, cam_data_in=wr_data, and cam_addr_in=lowest index with shadow bit 0.
  - Set that shadow bit at the clock edge.
  - Writes are independent of the lookup FSM and can be accepted every cycle.
- FSM states IDLE, LOOKUP, RESP:
  - IDLE: if any lk_req, pick a winner round-robin starting at rr_ptr, register its index, and go to LOOKUP. rr_ptr becomes winner+1 mod NREQ.
  - LOOKUP, exactly one cycle:
    - lk_gnt[idx]=1.
    - cam_mask_en=1; cam_mask_in/cam_mask_strb come from slice idx.
    - Register cam_hit, cam_data_out and cam_addr_out into the rsp_* outputs; force data and addr to 0 if !cam_hit.
    - If cam_hit && lk_pop[idx], assert cam_data_valid=1 and clear shadow bit cam_addr_out.
    - Go to RESP.
  - RESP: rsp_valid=1 with rsp_* held stable; on rsp_ready, go to IDLE.
- cam_mask_en, cam_data_valid and lk_gnt are 0 outside LOOKUP.
- count: +1 on write accept, −1 on pop, unchanged when both occur in one cycle.
  - full = count==DEPTH; empty = count==0.
- Write and pop in the same cycle: pop clears an occupied line, write targets a free line, so they never hit the same address.
- A lookup never sees a write accepted in the same cycle, because CAM storage is registered.

## Timing
- Lookup latency:
  - lk_req sampled in IDLE at cycle N.
  - lk_gnt and CAM access in cycle N+1.
  - rsp_valid from cycle N+2.
  - Back-to-back throughput: one lookup per 3 cycles with rsp_ready tied high.
- Write: zero-cycle acceptance. count/full update at the next edge.
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, rr_ptr=0, shadow=0, count=0.
  - rsp_valid=0, rsp_hit=0, rsp_data=0, rsp_addr=0, rsp_id=0, lk_gnt=0.
  - All cam_* outputs 0; empty=1, full=0, wr_ready=1.
- Reset mid-lookup drops the pending response; no rsp_valid is issued for it.
- The integrator must reset the CAM in the same cycle.
- Full: wr_ready=0 and wr_valid is ignored. Lookups continue.
- Empty: lookups return rsp_hit=0.
- Pop removes only the first (lowest-address) hit line.
- rsp_valid is never deasserted without rsp_ready; lk_req may drop only after lk_gnt.

## Configuration
- CAM_CTRL_POP_EN defined: lk_pop is honoured as described.
- Not defined:
  - lk_pop is ignored, cam_data_valid is tied 0, and lookups are non-destructive.
  - The shadow bitmap and count change only on writes.
  - The CAM fills monotonically until reset.

## Test plan
- Reset then 3 writes of 0xA0000001, 0x40000002, 0xA0000003 → cam_addr_in 0, 1, 2; count=3, empty=0.
- Requester 0 lookup with mask=3'b101, strb=3'b111, pop=1 → rsp_hit=1, rsp_addr=0, rsp_data=0xA0000001, count=2. Repeat → rsp_addr=2, count=1. Third lookup → rsp_hit=0, rsp_data=0, rsp_addr=0.
- lk_req=2'b11 held with rsp_ready=1 → grants alternate 0, 1, 0, 1; rsp_valid every 3rd cycle; rsp_id matches each grant.
- Write DEPTH entries → full=1, wr_ready=0, extra wr_valid dropped. Then pop one (addr 5) while wr_valid=1 in the same cycle → count stays DEPTH−1 at that edge and the next write allocates addr 5.
- rsp_ready=0 for 10 cycles in RESP → rsp_* stable and no new grant. Assert rst mid-RESP → rsp_valid=0 next cycle, count=0.
- Without CAM_CTRL_POP_EN: lookup with pop=1 hits → cam_data_valid never asserted, count unchanged, repeat lookup hits the same addr.
